// File: rtl/echo_pkg.sv
// Shared definitions for the echo delay-line sequencer and datapath.
package echo_pkg;

    localparam int unsigned ADDR_W        = 16;
    localparam int unsigned DEFAULT_DELAY = 9600;
    localparam int unsigned SAMPLE_W      = 16;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        WAIT,
        DONE
    } sched_state_t;

endpackage

// File: rtl/echo_fill_tracker.sv
// Saturating count of samples written since the last delay capture.
// The line is "filled" once the count reaches the delay.
module echo_fill_tracker #(
    parameter int unsigned ADDR_W = echo_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              advance,
    input  logic [ADDR_W-1:0] delay_reg,
    output logic              filled
);

    logic [ADDR_W-1:0] fill_cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            fill_cnt <= '0;
        end else if (advance) begin
            fill_cnt <= (fill_cnt >= delay_reg) ? delay_reg : fill_cnt + 1'b1;
        end
    end

    assign filled = (fill_cnt == delay_reg);

endmodule

// File: rtl/echo_delay_sched.sv
// Echo delay-line sequencer: turns each codec sample edge into write -> read -> mix,
// owns the write pointer and derives the read pointer from a loadable delay.
module echo_delay_sched #(
    parameter int unsigned ADDR_W        = echo_pkg::ADDR_W,
    parameter int unsigned DEFAULT_DELAY = echo_pkg::DEFAULT_DELAY,
    parameter int unsigned RAM_LAT       = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              new_sample_ready,
    input  logic              echo_enable,
    input  logic [ADDR_W-1:0] delay_len,
    input  logic              delay_load,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [ADDR_W-1:0] ram_raddr,
    output logic              mix_strobe,
    output logic              echo_valid,
    output logic              overrun
);
    import echo_pkg::*;

    localparam logic [ADDR_W-1:0] DELAY_INIT = ADDR_W'(DEFAULT_DELAY);
    localparam logic [1:0]        WAIT_LAST  = 2'(RAM_LAT - 1);

    sched_state_t      state;
    sched_state_t      state_nxt;
    logic              nsr_q;
    logic              strobe;
    logic [1:0]        wait_cnt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] delay_reg;
    logic [ADDR_W-1:0] pend_val;
    logic              pend;
    logic              idle_load;
    logic              done_capture;
    logic              capture;
    logic [ADDR_W-1:0] load_val;
    logic [ADDR_W-1:0] load_clamped;
    logic              filled;

    assign strobe = new_sample_ready & ~nsr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            nsr_q <= 1'b0;
        end else begin
            nsr_q <= new_sample_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (strobe) state_nxt = WRITE;
            WRITE:   state_nxt = READ;
            READ:    state_nxt = WAIT;
            WAIT:    if (wait_cnt == WAIT_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ram_we     = (state == WRITE);
        mix_strobe = (state == DONE);
        echo_valid = (state == DONE) & echo_enable & filled;
    end

    always_ff @(posedge clk) begin
        if (reset || state != WAIT) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Addresses are registered on entry to WRITE/READ so they hold through DONE and in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_waddr <= '0;
            ram_raddr <= '0;
            wr_ptr    <= '0;
        end else begin
            if (state == IDLE && strobe) ram_waddr <= wr_ptr;
            if (state == WRITE)          ram_raddr <= wr_ptr - delay_reg;
            if (state == DONE)           wr_ptr    <= wr_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (strobe && state != IDLE) begin
            overrun <= 1'b1;
        end
    end

    // A load in DONE itself is the newest request, so it bypasses the pending slot.
    assign idle_load    = delay_load & (state == IDLE) & ~strobe;
    assign done_capture = (state == DONE) & (pend | delay_load);
    assign capture      = idle_load | done_capture;
    assign load_val     = delay_load ? delay_len : pend_val;
    assign load_clamped = (load_val == '0) ? ADDR_W'(1) : load_val;

    always_ff @(posedge clk) begin
        if (reset) begin
            pend     <= 1'b0;
            pend_val <= '0;
        end else if (state == DONE) begin
            pend <= 1'b0;
        end else if (delay_load && !idle_load) begin
            pend     <= 1'b1;
            pend_val <= delay_len;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            delay_reg <= DELAY_INIT;
        end else if (capture) begin
            delay_reg <= load_clamped;
        end
    end

    echo_fill_tracker #(
        .ADDR_W (ADDR_W)
    ) u_fill (
        .clk       (clk),
        .reset     (reset),
        .clear     (capture),
        .advance   (state == DONE),
        .delay_reg (delay_reg),
        .filled    (filled)
    );

endmodule
